// File: rtl/lfsr_pkg.sv
// lfsr_pkg: mode enum and default 16-bit polynomial/seed shared by lfsr_gen and lfsr_next.
package lfsr_pkg;
    typedef enum logic {LFSR_FIB, LFSR_GALOIS} lfsr_mode_t;
    localparam logic [15:0] LFSR16_TAPS = 16'hB400;
    localparam logic [15:0] LFSR16_SEED = 16'hACE1;
endpackage

// File: rtl/lfsr_next.sv
// lfsr_next: purely combinational one-step LFSR update, Fibonacci or Galois form.
module lfsr_next import lfsr_pkg::*; #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = LFSR16_TAPS,
    parameter lfsr_mode_t       MODE  = LFSR_FIB
) (
    input  logic [WIDTH-1:0] CUR,
    output logic [WIDTH-1:0] NXT
);
    logic fb;
    always_comb begin
        fb = 1'b0;
        // tap k of the mask samples the bit k places down from the MSB
        for (int k = 0; k < WIDTH; k++) fb = fb ^ (TAPS[k] & CUR[WIDTH-1-k]);
        NXT = (MODE == LFSR_GALOIS) ? ((CUR >> 1) ^ (CUR[0] ? TAPS : '0)) : {fb, CUR[WIDTH-1:1]};
    end
endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: LFSR sequence generator with runtime load and lockup recovery.
// Define LFSR_GEN_CNT_EN to build the reference register, step counter and WRAP pulse.
module lfsr_gen import lfsr_pkg::*; #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = LFSR16_TAPS,
    parameter logic [WIDTH-1:0] SEED  = LFSR16_SEED,
    parameter lfsr_mode_t       MODE  = LFSR_FIB
) (
    input  logic             CLK,
    input  logic             n_RESET,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] SEED_IN,
    output logic [WIDTH-1:0] Q,
    output logic             BIT_OUT,
    output logic             LOCKUP,
    output logic             WRAP,
    output logic [WIDTH-1:0] STEP_CNT
);
    logic [WIDTH-1:0] nxt, step_q, load_q;
    logic             load_zero, q_zero;
    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be within 4..32");
    end
    if (TAPS == '0) begin : g_bad_taps
        $error("lfsr_gen: TAPS must be nonzero");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED must be nonzero");
    end
    lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS), .MODE(MODE)) u_next (.CUR(Q), .NXT(nxt));
    assign load_zero = SEED_IN == '0;
    assign q_zero    = Q == '0;
    assign load_q    = load_zero ? SEED : SEED_IN;
    assign step_q    = q_zero ? SEED : nxt;
    assign BIT_OUT   = Q[0];
    always_ff @(posedge CLK or negedge n_RESET) begin
        if (!n_RESET) begin
            Q      <= SEED;
            LOCKUP <= 1'b0;
        end else if (LOAD) begin
            Q      <= load_q;
            LOCKUP <= load_zero;
        end else if (EN) begin
            Q      <= step_q;
            LOCKUP <= LOCKUP | q_zero;
        end
    end
`ifdef LFSR_GEN_CNT_EN
    logic [WIDTH-1:0] ref_q;
    logic             hit;
    assign hit = step_q == ref_q;
    always_ff @(posedge CLK or negedge n_RESET) begin
        if (!n_RESET) begin
            ref_q    <= SEED;
            STEP_CNT <= '0;
            WRAP     <= 1'b0;
        end else if (LOAD) begin
            ref_q    <= load_q;
            STEP_CNT <= '0;
            WRAP     <= 1'b0;
        end else if (EN) begin
            STEP_CNT <= hit ? '0 : STEP_CNT + 1'b1;
            WRAP     <= hit;
        end
    end
`else
    assign STEP_CNT = '0;
    assign WRAP     = 1'b0;
`endif
endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 16: state width, legal range 4..32.
REQ-002 SHALL have parameter TAPS, default 16'hB400: Galois tap mask; bit k set means polynomial term x^(k+1). The default is x^16+x^14+x^13+x^11+1.
REQ-003 SHALL have parameter SEED, default 16'hACE1: reset and fallback state, nonzero.
REQ-004 SHALL have parameter MODE, default LFSR_FIB: LFSR_FIB or LFSR_GALOIS.
REQ-005 SHALL have port CLK, input, 1 bit: single clock, rising-edge.
REQ-006 SHALL have port n_RESET, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port EN, input, 1 bit: advance one step per clock while high.
REQ-008 SHALL have port LOAD, input, 1 bit: load SEED_IN this clock.
REQ-009 SHALL have port SEED_IN, input, WIDTH bits: runtime seed.
REQ-010 SHALL have port Q, output, WIDTH bits: current state.
REQ-011 SHALL have port BIT_OUT, output, 1 bit: serial output, equal to Q[0].
REQ-012 SHALL have port LOCKUP, output, 1 bit: sticky illegal-zero flag.
REQ-013 SHALL have port WRAP, output, 1 bit: one-cycle pulse on sequence return to the reference state.
REQ-014 SHALL have port STEP_CNT, output, WIDTH bits: steps since the last reset or load.

Function
REQ-015 Fibonacci step SHALL be Q <= {fb, Q[WIDTH-1:1]}, where fb = XOR of Q[WIDTH-1-k] over every set bit k of TAPS.
REQ-016 Galois step SHALL be Q <= (Q >> 1) ^ (Q[0] ? TAPS : 0).
REQ-017 Priority per rising edge SHALL be LOAD, then EN, then hold.
REQ-018 LOAD with nonzero SEED_IN SHALL set Q=SEED_IN, REF=SEED_IN, STEP_CNT=0 and clear LOCKUP.
REQ-019 LOAD with SEED_IN==0 SHALL set Q=SEED, REF=SEED, STEP_CNT=0 and set LOCKUP.
REQ-020 If Q==0 is ever observed with EN high, the next edge SHALL force Q=SEED and set LOCKUP.
REQ-021 LOCKUP SHALL stay high until reset or a legal LOAD.
REQ-022 Each EN step SHALL increment STEP_CNT modulo 2^WIDTH.
REQ-023 WRAP SHALL be a registered pulse, high for exactly the cycle after the step whose next state equals REF.
REQ-024 On that same step STEP_CNT SHALL reset to 0.
REQ-025 Q, STEP_CNT, LOCKUP and WRAP SHALL hold while EN is low.
REQ-026 WRAP SHALL be 0 on any cycle that follows a LOAD.
REQ-027 LOAD and EN both high SHALL be treated as a LOAD only, with no step.

Reset
REQ-028 While n_RESET is low, asynchronously: Q=SEED, REF=SEED, STEP_CNT=0, LOCKUP=0, WRAP=0.
REQ-029 Reset asserted mid-sequence SHALL discard all state.
REQ-030 The first step after release SHALL occur on the first rising edge with EN high.
REQ-031 The block SHALL NOT use initial-block state setting.

Configuration
REQ-032 With macro LFSR_GEN_CNT_EN defined, the REF register, the STEP_CNT counter and WRAP detection SHALL be built.
REQ-033 Without LFSR_GEN_CNT_EN, STEP_CNT and WRAP SHALL be tied to 0 and no REF register or counter flops SHALL exist.
REQ-034 Q, BIT_OUT and LOCKUP behaviour SHALL be identical in both configurations.

Structure
REQ-035 Package lfsr_pkg SHALL hold enum lfsr_mode_t {LFSR_FIB, LFSR_GALOIS} and constants LFSR16_TAPS=16'hB400 and LFSR16_SEED=16'hACE1.
REQ-036 Sub-module lfsr_next SHALL be a purely combinational next-state function, parameterised by WIDTH, TAPS and MODE.
REQ-037 lfsr_gen SHALL instance lfsr_next exactly once.
REQ-038 Elaboration SHALL fail for TAPS==0, SEED==0 or WIDTH outside 4..32.

Verification
REQ-039 FIB default: reset, then EN=1 for 1 cycle -> Q=16'h5670; after 3 cycles total, Q[15:13] follow the fb sequence matching a bench software model.
REQ-040 GALOIS default: reset, then EN=1 for 1 cycle -> Q=16'hE270, BIT_OUT=0.
REQ-041 Period, WIDTH=4, TAPS=4'hC, SEED=4'h1, macro defined: 15 EN cycles -> WRAP pulses once at step 15, STEP_CNT returns to 0, the 15 states are distinct and nonzero.
REQ-042 LOAD SEED_IN=0 -> Q=SEED and LOCKUP=1; then LOAD SEED_IN=16'h0001 -> Q=16'h0001 and LOCKUP=0.
REQ-043 LOAD and EN both high with SEED_IN=16'h1234 -> Q=16'h1234, STEP_CNT=0; EN low for 5 cycles -> Q is unchanged.
REQ-044 n_RESET pulsed low between clock edges mid-run -> Q=SEED immediately, without waiting for a clock edge; with the macro undefined, STEP_CNT and WRAP are 0 throughout.
